// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-bank completer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned ADDR_LSB       = $clog2(DEF_DATA_WIDTH / 8);
   localparam logic [31:0] DEF_ID_VALUE   = 32'hA9B0_0001;

   function automatic int unsigned addr_lsb(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word register storage: byte-enable write port, combinational read, flattened view.
// Register 0 is the read-only ID constant.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = 8,
   parameter logic [31:0] ID_VALUE   = DEF_ID_VALUE,
   localparam int unsigned IW        = $clog2(NUM_REGS),
   localparam int unsigned BW        = DATA_WIDTH / 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we,
   input  logic [IW-1:0]                  widx,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [BW-1:0]                  wbe,
   input  logic [IW-1:0]                  ridx,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

   localparam logic [DATA_WIDTH-1:0] ID_EXT = DATA_WIDTH'(ID_VALUE);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         for (int unsigned b = 0; b < BW; b++) begin
            if (wbe[b]) mem_d[widx][b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
      mem_d[0] = ID_EXT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
         mem_q[0] <= ID_EXT;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[ridx];

   always_comb begin
      reg_q = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
   end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer: register bank with programmable wait states and PSLVERR decode.
// Optional byte strobes: define APB_SLAVE_PSTRB_EN.
module apb_slave_regbank
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [31:0] ID_VALUE    = DEF_ID_VALUE
) (
   input  logic                           PCLK,
   input  logic                           PRESET,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`endif
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PREADY,
   output logic                           PSLVERR,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

   localparam int unsigned LSB = addr_lsb(DATA_WIDTH);
   localparam int unsigned BW  = DATA_WIDTH / 8;
   localparam int unsigned IW  = $clog2(NUM_REGS);
   localparam int unsigned XW  = ADDR_WIDTH - LSB;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BW-1:0]         pstrb_q, pstrb_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic [ADDR_WIDTH-1:0] addr_eff;
   logic                  write_eff;
   logic [BW-1:0]         pstrb_eff;
   logic [BW-1:0]         pstrb_in;
   logic [XW-1:0]         idx_full;
   logic                  err;
   logic [DATA_WIDTH-1:0] rf_rdata;

`ifdef APB_SLAVE_PSTRB_EN
   assign pstrb_in = PSTRB;
`else
   assign pstrb_in = '1;
`endif

   // With zero wait states DONE is entered straight from the setup cycle, so the
   // response is decoded from the live bus instead of the not-yet-latched copy.
   always_comb begin
      if (state_q == IDLE) begin
         addr_eff  = PADDR;
         write_eff = PWRITE;
         pstrb_eff = pstrb_in;
      end else begin
         addr_eff  = addr_q;
         write_eff = write_q;
         pstrb_eff = pstrb_q;
      end
   end

   always_comb begin
      idx_full = addr_eff[ADDR_WIDTH-1:LSB];
      err = (idx_full >= XW'(NUM_REGS)) || (|addr_eff[LSB-1:0]) ||
            (write_eff && (idx_full == '0));
`ifdef APB_SLAVE_PSTRB_EN
      if (!write_eff && (|pstrb_eff)) err = 1'b1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      pstrb_d   = pstrb_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               addr_d  = PADDR;
               write_d = PWRITE;
               wdata_d = PWDATA;
               pstrb_d = pstrb_in;
               cnt_d   = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_d   = DONE;
                  pready_d  = 1'b1;
                  pslverr_d = err;
                  prdata_d  = (err || write_eff) ? '0 : rf_rdata;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (PENABLE) begin
               if (cnt_q <= 4'd1) begin
                  state_d   = DONE;
                  cnt_d     = '0;
                  pready_d  = 1'b1;
                  pslverr_d = err;
                  prdata_d  = (err || write_eff) ? '0 : rf_rdata;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         pstrb_q   <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         pstrb_q   <= pstrb_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   apb_slave_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ID_VALUE   (ID_VALUE)
   ) u_regfile (
      .clk   (PCLK),
      .rst   (PRESET),
      .we    ((state_q == DONE) && write_q && !pslverr_q),
      .widx  (addr_q[LSB +: IW]),
      .wdata (wdata_q),
      .wbe   (pstrb_q),
      .ridx  (idx_full[IW-1:0]),
      .rdata (rf_rdata),
      .reg_q (reg_q)
   );

   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;
   assign PRDATA  = prdata_q;

endmodule
